uarttx: RTL
===========

UARTTX -- requirements
Module: uarttx

Interface
REQ-001 The block SHALL have parameter BAUD_PER, default 10416, meaning bit period minus one in clk cycles (9600 bps at 100 MHz); legal range 1..16383.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1, transmit enable; gates acceptance of new bytes only.
REQ-005 The block SHALL have port din, input, 8, byte to transmit.
REQ-006 The block SHALL have port valid, input, 1, din valid request.
REQ-007 The block SHALL have port ready, output, 1, high when a byte is accepted this cycle if valid is high.
REQ-008 The block SHALL have port tx, output, 1, serial line, idle high, driven from a register.

Function
REQ-009 The block SHALL implement ready as a combinational signal: high iff state is IDLE and en is high.
REQ-010 The block SHALL accept a byte on a rising edge where valid and ready are both high, capturing din into an 8-bit shift register.
REQ-011 The block SHALL ignore din changes after acceptance, and SHALL ignore valid while not in IDLE (no queuing).
REQ-012 The block SHALL implement states IDLE, START, DATA, STOP (plus PARITY per REQ-023): IDLE->START on accept; START->DATA, DATA->DATA (bits 0..6), DATA->STOP after bit 7, STOP->IDLE, each on a bit tick.
REQ-013 The block SHALL implement a 14-bit baud counter that clears to 0 on accept, counts 0..BAUD_PER, raises the bit tick at count BAUD_PER, then wraps to 0; every bit is held exactly BAUD_PER+1 cycles.
REQ-014 The block SHALL drive tx=0 in START, data LSB first in DATA (shift right one per tick), and tx=1 in STOP and IDLE.
REQ-015 The block SHALL have tx reflect the new state from the cycle after the accepting edge (one-cycle latency from accept to start-bit edge).
REQ-016 The block SHALL use a 3-bit data bit counter, cleared on accept, incremented per DATA tick; wrap from 7 coincides with DATA->STOP.
REQ-017 The block SHALL hold ready low for exactly 10*(BAUD_PER+1) cycles per frame (without parity).
REQ-018 The block SHALL return to IDLE so that ready is high in the first cycle after the stop bit; accepting then makes the next start bit follow the stop bit with zero idle cycles.
REQ-019 The block SHALL complete an in-progress frame normally when en falls mid-frame; ready then stays low until en rises.
REQ-020 The block SHALL NOT generate a bit tick in IDLE; the baud counter holds at 0 there.

Reset
REQ-021 The block SHALL, with rst high at a clock edge, force state IDLE, tx=1, shift register 0, bit counter 0, baud counter 0; ready then equals en.
REQ-022 The block SHALL, when rst is asserted mid-frame, abort the frame: tx returns high the cycle after the reset edge, with no partial stop bit and no pending byte retained.

Configuration
REQ-023 The block SHALL, with macro UARTTX_PARITY_EN defined, insert state PARITY between DATA and STOP transmitting even parity (XOR of the 8 captured data bits) for one bit period; the frame is then 11*(BAUD_PER+1) cycles.
REQ-024 The block SHALL, with UARTTX_PARITY_EN undefined, contain no parity logic and transition DATA->STOP directly; the frame is 10 bit periods.

Verification
REQ-025 Bench SHALL check: BAUD_PER=3, en=1, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; ready low exactly 40 cycles.
REQ-026 Bench SHALL check: back-to-back 0x00 then 0xFF with valid held high -> second start bit immediately after the first stop bit; 80 contiguous cycles, no idle gap.
REQ-027 Bench SHALL check: valid pulsed with din=0x3C during frame, then din changed to 0x55 -> frame carries original byte, extra valid ignored, only one frame sent.
REQ-028 Bench SHALL check: rst asserted at cycle 10 of a 0x00 frame -> tx=1 next cycle, ready=en, no further low bits.
REQ-029 Bench SHALL check: en=0 with valid=1 -> ready=0, tx stays 1; en dropped mid-frame -> frame completes, then ready stays 0.
REQ-030 Bench SHALL check: UARTTX_PARITY_EN defined, 0xA5 -> parity bit 0; 0x07 -> parity bit 1; ready low 44 cycles.

Source files
------------

// File: rtl/uarttx_if.sv
// Byte-stream port of the UART transmitter: handshake inputs, serial line and FSM debug view.
// Handshake: a byte transfers on a rising clk edge where valid and ready are both high; ready never depends on valid.
interface uarttx_if;
    logic       en;
    logic [7:0] din;
    logic       valid;
    logic       ready;
    logic       tx;
    logic [2:0] dbg_state;

    modport master (
        output en,
        output din,
        output valid,
        input  ready,
        input  tx,
        input  dbg_state
    );

    modport slave (
        input  en,
        input  din,
        input  valid,
        output ready,
        output tx,
        output dbg_state
    );
endinterface

// File: rtl/uarttx.sv
// 8N1 UART transmitter with registered tx and a BAUD_PER+1 cycle bit period.
// Define UARTTX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uarttx #(
    parameter int unsigned BAUD_PER = 10416
) (
    input  logic     clk,
    input  logic     rst,
    uarttx_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UARTTX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_e;

    localparam logic [13:0] BAUD_MAX = 14'(BAUD_PER);

    state_e      state_q, state_d;
    logic [13:0] baud_q, baud_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_q, tx_d;
`ifdef UARTTX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic ready;
    logic accept;
    logic tick;

    always_comb begin
        ready     = (state_q == IDLE) && bus.en;
        accept    = ready && bus.valid;
        tick      = (state_q != IDLE) && (baud_q == BAUD_MAX);

        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
`ifdef UARTTX_PARITY_EN
        parity_d  = parity_q;
`endif

        // The counter idles at 0, so an accept always starts a full bit period.
        if ((state_q == IDLE) || tick) begin
            baud_d = 14'd0;
        end else begin
            baud_d = baud_q + 14'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shift_d   = bus.din;
                    bit_cnt_d = 3'd0;
`ifdef UARTTX_PARITY_EN
                    parity_d  = ^bus.din;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UARTTX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UARTTX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is registered from the next state so the line changes on the same edge as the state.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UARTTX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= 14'd0;
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 1'b1;
`ifdef UARTTX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UARTTX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.ready     = ready;
    assign bus.tx        = tx_q;
    assign bus.dbg_state = state_q;

endmodule
